// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DIV_W = 4;

    // The counter must hold the value W itself, hence W+1 codes.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_restore_step
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_in_bit,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_rem_next,
    output logic         o_q_bit
);

    logic [W:0] w_t;
    logic [W:0] w_d;

    assign w_t = {i_rem, i_in_bit};
    assign w_d = w_t - {1'b0, i_divisor};

    // Keep the difference when the trial subtraction does not go negative.
    always_comb begin
        o_rem_next = w_t[W-1:0];
        o_q_bit    = 1'b0;
        if (w_t >= {1'b0, i_divisor}) begin
            o_rem_next = w_d[W-1:0];
            o_q_bit    = 1'b1;
        end else begin
            o_rem_next = w_t[W-1:0];
            o_q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, 2W/W -> W quotient and W remainder, one bit per clock.
// Optional quotient-overflow early exit when DIV_OVF_CHECK_EN is defined.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic [2*W-1:0] i_dividend,
    input  logic [W-1:0]   i_divisor,
    output logic           o_busy,
    output logic           o_done,
    output logic [W-1:0]   o_quotient,
    output logic [W-1:0]   o_remainder,
    output logic           o_dbz,
    output logic           o_ovf
);

    localparam int            CW      = cnt_width(W);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_W   = CW'(W);

    state_e        r_state, w_state_next;
    logic [W-1:0]  r_rem, w_rem_next;
    logic [W-1:0]  r_shift, w_shift_next;
    logic [W-1:0]  r_divisor, w_divisor_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_short, w_short_next;
    logic          r_busy, w_busy_next;
    logic          r_done, w_done_next;
    logic [W-1:0]  r_quot, w_quot_next;
    logic [W-1:0]  r_remo, w_remo_next;
    logic          r_dbz, w_dbz_next;

    logic          w_accept;
    logic          w_dbz_in;
    logic          w_short_in;
    logic [W-1:0]  w_step_rem;
    logic          w_step_q;

    assign w_accept = (r_state != BUSY) && i_start;
    assign w_dbz_in = (i_divisor == {W{1'b0}});

`ifdef DIV_OVF_CHECK_EN
    logic r_ovf, w_ovf_next;
    logic w_ovf_in;
    assign w_ovf_in   = !w_dbz_in && (i_dividend[2*W-1:W] >= i_divisor);
    assign w_short_in = w_dbz_in || w_ovf_in;
    assign o_ovf      = r_ovf;
`else
    assign w_short_in = w_dbz_in;
    assign o_ovf      = 1'b0;
`endif

    div_restore_step #(.W(W)) u_step (
        .i_rem      (r_rem),
        .i_in_bit   (r_shift[W-1]),
        .i_divisor  (r_divisor),
        .o_rem_next (w_step_rem),
        .o_q_bit    (w_step_q)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; special cases pass through BUSY for a single cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_state_next = BUSY;
                end else begin
                    w_state_next = IDLE;
                end
            end
            BUSY: begin
                if (r_cnt == CNT_ONE) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = BUSY;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        w_rem_next     = r_rem;
        w_shift_next   = r_shift;
        w_divisor_next = r_divisor;
        w_cnt_next     = r_cnt;
        w_short_next   = r_short;
        w_quot_next    = r_quot;
        w_remo_next    = r_remo;
        w_dbz_next     = r_dbz;
`ifdef DIV_OVF_CHECK_EN
        w_ovf_next     = r_ovf;
`endif
        w_busy_next    = (w_state_next == BUSY);
        w_done_next    = (w_state_next == DONE);
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_divisor_next = i_divisor;
                    w_rem_next     = i_dividend[2*W-1:W];
                    w_shift_next   = i_dividend[W-1:0];
                    w_short_next   = w_short_in;
                    w_cnt_next     = w_short_in ? CNT_ONE : CNT_W;
                    w_dbz_next     = 1'b0;
`ifdef DIV_OVF_CHECK_EN
                    w_ovf_next     = 1'b0;
`endif
                end else begin
                    w_short_next = r_short;
                end
            end
            BUSY: begin
                w_cnt_next = r_cnt - CNT_ONE;
                if (r_short) begin
                    // Saturated result; the untouched low dividend half becomes the remainder.
                    w_quot_next = {W{1'b1}};
                    w_remo_next = r_shift;
                    w_dbz_next  = (r_divisor == {W{1'b0}});
`ifdef DIV_OVF_CHECK_EN
                    w_ovf_next  = (r_divisor != {W{1'b0}});
`endif
                end else begin
                    w_rem_next   = w_step_rem;
                    w_shift_next = {r_shift[W-2:0], w_step_q};
                    if (r_cnt == CNT_ONE) begin
                        w_quot_next = {r_shift[W-2:0], w_step_q};
                        w_remo_next = w_step_rem;
                    end else begin
                        w_quot_next = r_quot;
                    end
                end
            end
            default: begin
                w_cnt_next = {CW{1'b0}};
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rem     <= {W{1'b0}};
            r_shift   <= {W{1'b0}};
            r_divisor <= {W{1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_short   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_quot    <= {W{1'b0}};
            r_remo    <= {W{1'b0}};
            r_dbz     <= 1'b0;
`ifdef DIV_OVF_CHECK_EN
            r_ovf     <= 1'b0;
`endif
        end else begin
            r_rem     <= w_rem_next;
            r_shift   <= w_shift_next;
            r_divisor <= w_divisor_next;
            r_cnt     <= w_cnt_next;
            r_short   <= w_short_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_quot    <= w_quot_next;
            r_remo    <= w_remo_next;
            r_dbz     <= w_dbz_next;
`ifdef DIV_OVF_CHECK_EN
            r_ovf     <= w_ovf_next;
`endif
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_quotient  = r_quot;
    assign o_remainder = r_remo;
    assign o_dbz       = r_dbz;

endmodule
